// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the
// pipeline writeback and a buffered long-latency result source.
// Ports:
//   CLK, RST (async, active-low)
//   PIPE_WB_VALID/DES/DATA in, PIPE_STALL out (comb)
//   LL_VALID/DES/DATA in, LL_READY out (comb)
//   WB_VALID/DES/DATA out (reg), LL_PENDING out (reg)
//   STAT_STALL_CNT out, present only with WB_ARB_STATS_EN defined
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PIPE_WB_VALID,
  input  logic [4:0]        PIPE_WB_DES,
  input  logic [DATA_W-1:0] PIPE_WB_DATA,
  output logic              PIPE_STALL,
  input  logic              LL_VALID,
  input  logic [4:0]        LL_DES,
  input  logic [DATA_W-1:0] LL_DATA,
  output logic              LL_READY,
  output logic              WB_VALID,
  output logic [4:0]        WB_DES,
  output logic [DATA_W-1:0] WB_DATA,
  output logic              LL_PENDING
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]       STAT_STALL_CNT
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]        ent_des  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_vld;
  logic [DEPTH-1:0]  vld_nxt;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve;

  logic buf_empty;
  logic head_live;
  logic head_dead;
  logic pipe_req;
  logic starved;
  logic gnt_buf;
  logic gnt_pipe;
  logic ll_acc;
  logic bypass;
  logic superseded;
  logic enq;
  logic pop;

  assign buf_empty = (count == '0);
  assign head_live = !buf_empty && ent_vld[head];
  assign head_dead = !buf_empty && !ent_vld[head];
  // x0 pipeline writes never need the port
  assign pipe_req  = PIPE_WB_VALID && (PIPE_WB_DES != 5'd0);
  assign starved   = head_live && (starve == SW'(STARVE_MAX));
  assign gnt_buf   = head_live && (starved || !pipe_req);
  assign gnt_pipe  = pipe_req && !starved;
  assign PIPE_STALL = starved && pipe_req;

  assign LL_READY  = (count < CW'(DEPTH));
  assign ll_acc    = LL_VALID && LL_READY;
  assign bypass    = ll_acc && buf_empty && !pipe_req;
  // a same-cycle pipeline write to this DES is younger: drop LL result
  assign superseded = gnt_pipe && (LL_DES == PIPE_WB_DES);
  assign enq = ll_acc && !bypass && (LL_DES != 5'd0) && !superseded;
  assign pop = gnt_buf || head_dead;

  // valid bits are cleared on pop, so only occupied slots can be live
  always_comb begin
    vld_nxt = ent_vld;
    if (pop) vld_nxt[head] = 1'b0;
    if (gnt_pipe) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_des[i] == PIPE_WB_DES) vld_nxt[i] = 1'b0;
      end
    end
    if (enq) vld_nxt[tail] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      ent_des[tail]  <= LL_DES;
      ent_data[tail] <= LL_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ent_vld    <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve     <= '0;
      WB_VALID   <= 1'b0;
      WB_DES     <= 5'd0;
      WB_DATA    <= '0;
      LL_PENDING <= 1'b0;
    end else begin
      ent_vld    <= vld_nxt;
      LL_PENDING <= |vld_nxt;
      head  <= head + PW'(pop);
      tail  <= tail + PW'(enq);
      count <= count + CW'(enq) - CW'(pop);
      if (gnt_buf || buf_empty) begin
        starve <= '0;
      end else if (gnt_pipe && (starve != SW'(STARVE_MAX))) begin
        starve <= starve + SW'(1);
      end
      unique case (1'b1)
        gnt_buf: begin
          WB_VALID <= 1'b1;
          WB_DES   <= ent_des[head];
          WB_DATA  <= ent_data[head];
        end
        gnt_pipe: begin
          WB_VALID <= 1'b1;
          WB_DES   <= PIPE_WB_DES;
          WB_DATA  <= PIPE_WB_DATA;
        end
        bypass: begin
          WB_VALID <= (LL_DES != 5'd0);
          WB_DES   <= LL_DES;
          WB_DATA  <= LL_DATA;
        end
        default: WB_VALID <= 1'b0;
      endcase
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      STAT_STALL_CNT <= '0;
    end else if (PIPE_STALL && (STAT_STALL_CNT != '1)) begin
      STAT_STALL_CNT <= STAT_STALL_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: vector table plus scoreboarded multi-cycle
// sequences for wb_port_arbiter (DATA_W=32, DEPTH=2, STARVE_MAX=4).
module tb_wb_port_arbiter;

  logic        CLK;
  logic        RST;
  logic        pv;
  logic [4:0]  pdes;
  logic [31:0] pdata;
  logic        stall;
  logic        lv;
  logic [4:0]  ldes;
  logic [31:0] ldata;
  logic        ready;
  logic        wbv;
  logic [4:0]  wdes;
  logic [31:0] wdata;
  logic        pend;
`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_cnt;
`endif

  wb_port_arbiter #(
    .DATA_W(32), .DEPTH(2), .STARVE_MAX(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .PIPE_WB_VALID(pv),
    .PIPE_WB_DES(pdes),
    .PIPE_WB_DATA(pdata),
    .PIPE_STALL(stall),
    .LL_VALID(lv),
    .LL_DES(ldes),
    .LL_DATA(ldata),
    .LL_READY(ready),
    .WB_VALID(wbv),
    .WB_DES(wdes),
    .WB_DATA(wdata),
    .LL_PENDING(pend)
`ifdef WB_ARB_STATS_EN
    ,
    .STAT_STALL_CNT(stat_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        pv;
    logic [4:0]  pd;
    logic [31:0] pdat;
    logic        lv;
    logic [4:0]  ld;
    logic [31:0] ldat;
    logic        stall;
    logic        ready;
    logic        wbv;
    logic [4:0]  wdes;
    logic [31:0] wdat;
    logic        pend;
  } vec_t;

  vec_t tbl [13];

  int checks;
  int errors;
  logic [36:0] pipe_q [$];
  logic [36:0] ll_q [$];
  logic stall_s;
  logic ready_s;
  int pidx;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic p, logic [4:0] pd, logic [31:0] pdt,
    logic l, logic [4:0] ld, logic [31:0] ldt,
    logic st, logic rd, logic w, logic [4:0] wd,
    logic [31:0] wdt, logic pn);
    vec_t v;
    v.pv = p; v.pd = pd; v.pdat = pdt;
    v.lv = l; v.ld = ld; v.ldat = ldt;
    v.stall = st; v.ready = rd; v.wbv = w;
    v.wdes = wd; v.wdat = wdt; v.pend = pn;
    return v;
  endfunction

  function automatic logic [4:0] pd_of(int i);
    return 5'(16 + (i % 8));
  endfunction

  function automatic logic [31:0] pdat_of(int i);
    return 32'(32'h1000 + i);
  endfunction

  task automatic sb_check();
    logic [36:0] got;
    if (wbv) begin
      got = {wdes, wdata};
      checks++;
      if (pipe_q.size() > 0 && pipe_q[0] == got) begin
        void'(pipe_q.pop_front());
      end else if (ll_q.size() > 0 && ll_q[0] == got) begin
        void'(ll_q.pop_front());
      end else begin
        errors++;
        $display("FAIL sb_write got des=%0d data=%0h want pipe=%0h ll=%0h",
                 wdes, wdata,
                 (pipe_q.size() > 0) ? pipe_q[0] : 37'h0,
                 (ll_q.size() > 0) ? ll_q[0] : 37'h0);
      end
    end
  endtask

  // entered at posedge+1, returns at the next posedge+1
  task automatic cyc(input logic pon, input logic [4:0] pd,
                     input logic [31:0] pdt, input logic lon,
                     input logic [4:0] ld, input logic [31:0] ldt,
                     input logic ll_live);
    pv = pon; pdes = pd; pdata = pdt;
    lv = lon; ldes = ld; ldata = ldt;
    #2;
    stall_s = stall;
    ready_s = ready;
    if (pon && !stall_s && pd != 5'd0) pipe_q.push_back({pd, pdt});
    if (lon && ready_s && ll_live && ld != 5'd0) ll_q.push_back({ld, ldt});
    @(posedge CLK);
    #1;
    sb_check();
    pv = 1'b0;
    lv = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 0, 0, 0);
    chk({nm, "_queues"}, 64'(pipe_q.size() + ll_q.size()), 0);
    chk({nm, "_pend"}, pend, 0);
  endtask

  initial begin
    logic saw_block;
    int li;
    checks = 0;
    errors = 0;
    pv = 0; pdes = 0; pdata = 0;
    lv = 0; ldes = 0; ldata = 0;

    tbl[0]  = mk(1, 1, 32'h10, 0, 0, 0, 0, 1, 1, 1, 32'h10, 0);
    tbl[1]  = mk(1, 2, 32'h11, 0, 0, 0, 0, 1, 1, 2, 32'h11, 0);
    tbl[2]  = mk(1, 3, 32'h12, 0, 0, 0, 0, 1, 1, 3, 32'h12, 0);
    tbl[3]  = mk(1, 4, 32'h13, 0, 0, 0, 0, 1, 1, 4, 32'h13, 0);
    tbl[4]  = mk(1, 5, 32'h14, 0, 0, 0, 0, 1, 1, 5, 32'h14, 0);
    tbl[5]  = mk(0, 0, 0, 1, 7, 32'hDEAD, 0, 1, 1, 7, 32'hDEAD, 0);
    tbl[6]  = mk(0, 0, 0, 1, 0, 32'h55, 0, 1, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 32'h66, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 32'h66, 1, 5, 32'h77, 0, 1, 1, 5, 32'h77, 0);
    tbl[9]  = mk(1, 3, 32'h33, 1, 3, 32'h99, 0, 1, 1, 3, 32'h33, 0);
    tbl[10] = mk(1, 4, 32'h44, 1, 6, 32'h88, 0, 1, 1, 4, 32'h44, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 32'h88, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    RST = 1'b1;
    #1 RST = 1'b0;
    #5;
    chk("rst_wbv", wbv, 0);
    chk("rst_des", wdes, 0);
    chk("rst_data", wdata, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ready", ready, 1);
`ifdef WB_ARB_STATS_EN
    chk("rst_stat", stat_cnt, 0);
`endif
    @(posedge CLK);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 13; i++) begin
      pv = tbl[i].pv; pdes = tbl[i].pd; pdata = tbl[i].pdat;
      lv = tbl[i].lv; ldes = tbl[i].ld; ldata = tbl[i].ldat;
      #2;
      chk($sformatf("v%0d_stall", i), stall, tbl[i].stall);
      chk($sformatf("v%0d_ready", i), ready, tbl[i].ready);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_wbv", i), wbv, tbl[i].wbv);
      if (tbl[i].wbv) begin
        chk($sformatf("v%0d_des", i), wdes, tbl[i].wdes);
        chk($sformatf("v%0d_data", i), wdata, tbl[i].wdat);
      end
      chk($sformatf("v%0d_pend", i), pend, tbl[i].pend);
    end
    pv = 0; lv = 0;

    // starvation: LL x9 buffered behind a continuous pipe stream
    pidx = 0;
    for (int c = 0; c < 12 && pidx < 8; c++) begin
      cyc(1, pd_of(pidx), pdat_of(pidx), c == 0, 9, 32'h900, 1);
      chk($sformatf("a_stall_c%0d", c), stall_s, c == 5);
      if (c == 0) chk("a_ready", ready_s, 1);
      if (c == 5) chk("a_wb9", {wbv, wdes}, {1'b1, 5'd9});
      if (c == 6) chk("a_held", {wbv, wdes}, {1'b1, pd_of(5)});
      if (!stall_s) pidx++;
    end
    drain("a");
`ifdef WB_ARB_STATS_EN
    chk("a_stat", stat_cnt, 1);
`endif

    // kill: buffered x12 superseded by a younger pipe write
    cyc(1, 20, 32'h200, 1, 12, 32'hBB, 0);
    chk("b_ready", ready_s, 1);
    chk("b_pend1", pend, 1);
    cyc(1, 12, 32'hAA, 0, 0, 0, 0);
    chk("b_stall", stall_s, 0);
    chk("b_pend0", pend, 0);
    drain("b");

    // full buffer: third LL result back-pressured, all land in order
    pidx = 0;
    li = 0;
    saw_block = 0;
    for (int c = 0; c < 40 && (li < 3 || pidx < 14); c++) begin
      cyc(1, pd_of(pidx), pdat_of(pidx), li < 3,
          5'(25 + li), 32'(32'hC0 + li), 1);
      if (c == 2) chk("c_full", ready_s, 0);
      if (li < 3 && !ready_s) saw_block = 1;
      if (li < 3 && ready_s) li++;
      if (!stall_s) pidx++;
    end
    chk("c_block", saw_block, 1);
    chk("c_accepted", li, 3);
    drain("c");

    // reset mid-operation drops the buffered entry
    cyc(1, 21, 32'h300, 1, 30, 32'hEE, 0);
    chk("d_pend1", pend, 1);
    #1 RST = 1'b0;
    #1;
    chk("d_rst_wbv", wbv, 0);
    chk("d_rst_pend", pend, 0);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK);
    #1;
    drain("d");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (WB_DES/WB_DATA/valid into the decode-stage register array) between two sources:
  - the in-order pipeline writeback (MEM3/WB);
  - a long-latency unit such as the multiplier/divider.
- Buffers long-latency results that cannot write immediately.
- Prevents starvation by stalling the pipeline writeback.
- Kills stale buffered writes that a younger pipeline write to the same register has superseded.

Parameters:
- DATA_W, 32, write data width.
- DEPTH, 2, long-latency result buffer entries (power of 2, >=2).
- STARVE_MAX, 4, consecutive cycles a non-empty buffer may lose the port before the pipeline is forced to stall (>=1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- PIPE_WB_VALID  in  1  pipeline writeback request.
- PIPE_WB_DES  in  5  pipeline destination register.
- PIPE_WB_DATA  in  DATA_W  pipeline write data.
- PIPE_STALL  out  1  pipeline must hold its writeback this cycle; combinational.
- LL_VALID  in  1  long-latency result offered.
- LL_DES  in  5  long-latency destination.
- LL_DATA  in  DATA_W  long-latency data.
- LL_READY  out  1  result accepted when LL_VALID & LL_READY; combinational.
- WB_VALID  out  1  register-file write enable; registered.
- WB_DES  out  5  register-file write address; registered.
- WB_DATA  out  DATA_W  register-file write data; registered.
- LL_PENDING  out  1  buffer holds at least one live entry; registered.

Behaviour:
- Reset (RST low, async):
  - WB_VALID=0, WB_DES=0, WB_DATA=0, LL_PENDING=0.
  - Buffer empty, all entry valid bits 0, starve counter 0.
- LL_READY = (occupancy < DEPTH). Occupancy counts killed-but-unpopped entries. No same-cycle dequeue bypass.
- Per-cycle grant decision, in priority order:
  1. Head entry killed: pop it with no write. It does not consume the port. Arbitration continues with the remaining sources.
  2. Buffer live head and starve counter == STARVE_MAX: grant buffer. If PIPE_WB_VALID, assert PIPE_STALL. The pipeline re-presents the same write next cycle.
  3. PIPE_WB_VALID: grant pipeline.
  4. Buffer live head: grant buffer.
  5. Buffer empty and LL_VALID: direct bypass. LL is granted and not enqueued.
- LL handshake that is not a bypass: enqueue at tail with valid=1.
- Write latency:
  - Granted write appears on WB_* exactly one cycle after the grant.
  - Bypassed LL result therefore has 1-cycle latency; buffered results have >=2.
- x0 writes:
  - DES==0 never produces WB_VALID.
  - Pipeline x0: no grant used.
  - LL x0: accepted, then discarded.
- Starve counter:
  - Increments (saturating at STARVE_MAX) each cycle the buffer has a live head and the pipeline is granted.
  - Clears on a buffer grant or when the buffer is empty.
- Kill rule: on a pipeline grant with DES!=0, clear the valid bit of every buffered entry whose DES matches.
- Simultaneous arrival: if an LL result arrives in the same cycle as a granted pipeline write to the same DES, the LL result is accepted and discarded. The pipeline write is the younger one.
- Full buffer with LL_VALID: LL_READY=0. The LL unit holds its result; it is not lost.
- Pointers wrap modulo DEPTH.
- LL_PENDING reflects live entries after the current cycle's updates.
- Reset mid-operation: all buffered results are dropped, with no partial write.

Optional Feature:
- Macro WB_ARB_STATS_EN.
- Defined: adds output STAT_STALL_CNT (32-bit, saturating).
  - Counts cycles with PIPE_STALL=1.
  - Resets to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Pipe-only stream x1..x5 with data 0x10..0x14 -> WB_* shows the same sequence one cycle later; LL_PENDING=0; PIPE_STALL never asserted.
- Idle pipe, LL_VALID with DES=7, DATA=0xDEAD -> LL_READY=1; next cycle WB_VALID=1, WB_DES=7, WB_DATA=0xDEAD (bypass).
- Continuous pipe writes plus one LL result (DES=9), STARVE_MAX=4:
  - LL is buffered and loses 4 cycles;
  - cycle 5: PIPE_STALL=1 and the buffer is granted;
  - next cycle: WB_DES=9; the held pipe write follows.
- Buffer LL DES=12 (pipe busy), then pipe writes DES=12 with 0xAA -> the buffered entry is killed; only 0xAA is written to x12; LL_PENDING falls to 0.
- Pipe busy, three LL results with DEPTH=2 -> LL_READY=0 on the third until a pop; all three results are eventually written in order.
- LL DES=0 and pipe DES=0 -> WB_VALID stays 0; the LL handshake completes. With WB_ARB_STATS_EN, STAT_STALL_CNT counts exactly the forced-stall cycles from the starvation scenario.
